// File: rtl/ebox_pkg.sv
// ebox_pkg: shared EBOX types and helpers.
//   tCRADR          - CRAM address (11 bits on the production machine)
//   tSbrEntry       - one subroutine-stack entry: address plus even parity bit
//   CRA_STACK_DEPTH - production depth of the CALL/RETURN stack
//   sbrParity()     - parity generator/checker for stack entries
package ebox_pkg;

  localparam int CRA_ADR_W       = 11;
  localparam int CRA_STACK_DEPTH = 16;

  // Widest address sbrParity accepts. Narrower addresses are zero-extended
  // by the caller, which leaves the XOR-reduction parity unchanged.
  localparam int CRA_PAR_MAX_W   = 64;

  typedef logic [CRA_ADR_W-1:0] tCRADR;

  typedef struct packed {
    tCRADR adr;
    logic  par;
  } tSbrEntry;

  function automatic logic sbrParity(input logic [CRA_PAR_MAX_W-1:0] adr);
    return ^adr;
  endfunction

endpackage

// File: rtl/cra_sbr_stack.sv
// cra_sbr_stack: parametrised microcode CALL/RETURN stack for the CRAM address path.
//   clk        CLK.CRA, every state change on the rising edge
//   RESET      CLK.MR_RESET, synchronous, active-high; dominates all other inputs
//   call       CRAM.CALL: push cradr
//   force1777  CLK.FORCE_1777: page-fail synthetic call, also pushes cradr
//   ret        CTL.DISP_RETURN: pop into sbrRet (ignored when a push is requested)
//   cradr      current CRADR, the value pushed
//   sbrRet     registered return address (SBR_RET dispatch source)
//   sp         next-empty slot index
//   count      occupied entries, 0..DEPTH
//   overflow   sticky: push while full (oldest entry overwritten)
//   underflow  sticky: pop while empty
//   parErr     sticky: popped entry failed its parity check
//   clrErr     clears the three sticky flags; a same-cycle new error wins
//   diagIdx    diagnostic depth, 0 = top of stack
//   diagData   combinational read of entry (sp-1-diagIdx) mod DEPTH
module cra_sbr_stack
  import ebox_pkg::*;
#(
  parameter int ADR_W = CRA_ADR_W,
  parameter int DEPTH = CRA_STACK_DEPTH,
  parameter int SP_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             call,
  input  logic             force1777,
  input  logic             ret,
  input  logic [ADR_W-1:0] cradr,
  output logic [ADR_W-1:0] sbrRet,
  output logic [SP_W-1:0]  sp,
  output logic [SP_W:0]    count,
  output logic             overflow,
  output logic             underflow,
  output logic             parErr,
  input  logic             clrErr,
  input  logic [SP_W-1:0]  diagIdx,
  output logic [ADR_W-1:0] diagData
);

  // Same layout as tSbrEntry, but sized by ADR_W so non-default widths work.
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic             par;
  } entry_t;

  localparam logic [SP_W:0] FULL_COUNT = (SP_W+1)'(DEPTH);

  entry_t           stack_q [DEPTH];

  logic [SP_W-1:0]  sp_q, sp_d;
  logic [SP_W:0]    count_q, count_d;
  logic [ADR_W-1:0] sbr_ret_q, sbr_ret_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             par_err_q, par_err_d;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [SP_W-1:0]  top_idx;
  logic [SP_W-1:0]  diag_idx_eff;
  entry_t           top_entry;
  entry_t           wr_entry;

  assign push         = call | force1777;
  // A push (CALL or page-fail) suppresses a return in the same cycle.
  assign pop          = ret & ~push;
  assign full         = (count_q == FULL_COUNT);
  assign empty        = (count_q == '0);
  // SP_W-bit arithmetic gives the modulo-DEPTH wrap for free (DEPTH is 2**SP_W).
  assign top_idx      = sp_q - 1'b1;
  assign diag_idx_eff = sp_q - 1'b1 - diagIdx;
  assign top_entry    = stack_q[top_idx];

  always_comb begin
    wr_entry.adr = cradr;
    wr_entry.par = sbrParity(CRA_PAR_MAX_W'(cradr));
  end

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    sp_d      = sp_q;
    count_d   = count_q;
    sbr_ret_d = sbr_ret_q;
    // Clear is applied first so a fresh error below overrides it.
    ovf_d     = clrErr ? 1'b0 : ovf_q;
    unf_d     = clrErr ? 1'b0 : unf_q;
    par_err_d = clrErr ? 1'b0 : par_err_q;

    if (push) begin
      sp_d = sp_q + 1'b1;
      if (full) begin
        // Circular overwrite of the oldest entry; count saturates.
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        sbr_ret_d = top_entry.adr;
        sp_d      = top_idx;
        count_d   = count_q - 1'b1;
        if (sbrParity(CRA_PAR_MAX_W'(top_entry.adr)) != top_entry.par) begin
          par_err_d = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (RESET) begin
      sp_q      <= '0;
      count_q   <= '0;
      sbr_ret_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      count_q   <= count_d;
      sbr_ret_q <= sbr_ret_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      par_err_q <= par_err_d;
    end
  end

  // NOTE: the storage array has no reset; only the pointer and count are
  // cleared, so stale contents are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (!RESET && push) begin
      stack_q[sp_q] <= wr_entry;
    end
  end

  assign sbrRet    = sbr_ret_q;
  assign sp        = sp_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign parErr    = par_err_q;
  assign diagData  = stack_q[diag_idx_eff].adr;

endmodule
